exe_muldiv: RTL and testbench
=============================

EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk_i  input  1  clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 valid_i  input  1  ID/EX stage holds an RV32M instruction (opcode 0110011, funct7 0000001).
REQ-005 funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1_i  input  32  operand A (ID/EX data1).
REQ-007 rs2_i  input  32  operand B (ID/EX data2).
REQ-008 rd_i  input  5  destination register.
REQ-009 flush_i  input  1  kill in-flight op (branch/jump flush).
REQ-010 stall_o  output  1  hold PC, IF/ID and ID/EX; insert no new instruction.
REQ-011 done_o  output  1  one-cycle pulse; result_o/rd_o valid.
REQ-012 result_o  output  32  operation result.
REQ-013 rd_o  output  5  destination of result_o.

Function
REQ-014 States: IDLE, CALC, FIX, DONE.
REQ-015 IDLE: valid_i=1 and flush_i=0 -> latch funct3_i, rd_i, operand magnitudes and result sign; go CALC with 5-bit counter 0, or DONE directly on fast path (REQ-021).
REQ-016 Signed ops (MULH both operands; MULHSU rs1 only; DIV/REM both) use two's-complement magnitude of negative operands; unsigned ops use raw values.
REQ-017 CALC: 32 iterations, one per cycle; multiply = shift-add into 64-bit accumulator; divide = restoring, one quotient bit per cycle; counter 31 -> FIX.
REQ-018 FIX: negate product if signA^signB; negate quotient if signA^signB; negate remainder if signA; register result_o and rd_o; go DONE.
REQ-019 Result select: MUL low 32 product bits; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder.
REQ-020 DONE: done_o=1 for exactly this cycle; go IDLE unconditionally (pipeline advances this edge; valid_i next cycle is a new instruction).
REQ-021 Fast path, no CALC/FIX: divisor 0 -> quotient 0xFFFFFFFF, remainder rs1_i; DIV/REM with rs1_i=0x80000000, rs2_i=0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-022 Latency, cycle 0 = first IDLE cycle with valid_i=1: normal done_o in cycle 34 (CALC 1-32, FIX 33); fast path done_o in cycle 1.
REQ-023 stall_o = (IDLE and valid_i and !flush_i) or CALC or FIX; combinational; low in DONE.
REQ-024 flush_i=1 in any state: next state IDLE, done_o not asserted, stall_o=0 that cycle; result_o/rd_o unchanged.
REQ-025 result_o and rd_o hold last completed value until next FIX or fast-path completion.
REQ-026 valid_i, funct3_i, operands ignored outside IDLE (ID/EX held by stall_o).
REQ-027 Back-to-back M ops: second accepted in the IDLE cycle after DONE; no idle gap beyond that.

Reset
REQ-028 rst_i=1 -> state IDLE, counter 0, accumulator 0, result_o 0, rd_o 0, done_o 0; stall_o 0 while rst_i=1.
REQ-029 Reset mid-CALC aborts without done_o; first valid_i after release starts a fresh op.

Verification
REQ-030 MUL rs1=7, rs2=0xFFFFFFFD, rd=5 -> stall_o high cycles 0-33, done_o only in cycle 34, result_o=0xFFFFFFEB, rd_o=5.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000: each with stall_o high only cycle 0, done_o in cycle 1.
REQ-034 flush_i in cycle 10 of a DIV -> stall_o low that cycle, IDLE next, no done_o, result_o unchanged; then MUL 3*4 -> 12 in cycle 34.
REQ-035 rst_i pulsed in cycle 20 of a MUL -> all outputs 0 immediately, no done_o; back-to-back MUL then DIVU after release both complete correctly.

Source files
------------

// File: rtl/exe_muldiv_if.sv
// ID/EX <-> multiply/divide unit handshake bundle.
// The master side is the pipeline (issues an op and honours stall_o); the slave side is exe_muldiv.
interface exe_muldiv_if;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  modport master (
    output valid_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
    input  stall_o, done_o, result_o, rd_o
  );

  modport slave (
    input  valid_i, funct3_i, rs1_i, rs2_i, rd_i, flush_i,
    output stall_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/exe_muldiv.sv
// RV32M multi-cycle execute unit.
// - Multiply: 32-step shift-add on operand magnitudes.
// - Divide: 32-step restoring division on operand magnitudes.
// - Signs are fixed up in a single FIX cycle.
// - Divide-by-zero and signed overflow skip the iteration and finish one cycle after acceptance.
module exe_muldiv (
  input  logic       clk_i,
  input  logic       rst_i,
  exe_muldiv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [31:0] opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic        neg_p;    // product/quotient sign
  logic        neg_r;    // remainder sign (follows dividend)
  logic [31:0] result_q;
  logic [4:0]  rd_oq;

  // ---------------------------------------------------------------------------
  // Issue-time decode: operand signs, magnitudes and the fast-path cases.
  // ---------------------------------------------------------------------------
  logic        is_div, sgn_a_op, sgn_b_op, sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic        div_zero, div_ovf, fast;
  logic [31:0] fast_res;
  logic        accept;

  // Signed-operand selection and fast-path detection from the ID/EX fields
  always_comb begin
    is_div   = bus.funct3_i[2];
    sgn_a_op = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
               (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    sgn_b_op = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
               (bus.funct3_i == 3'b110);
    sign_a   = sgn_a_op && bus.rs1_i[31];
    sign_b   = sgn_b_op && bus.rs2_i[31];
    mag_a    = sign_a ? (32'd0 - bus.rs1_i) : bus.rs1_i;
    mag_b    = sign_b ? (32'd0 - bus.rs2_i) : bus.rs2_i;
    div_zero = is_div && (bus.rs2_i == 32'd0);
    div_ovf  = is_div && !bus.funct3_i[0] &&
               (bus.rs1_i == 32'h8000_0000) && (bus.rs2_i == 32'hFFFF_FFFF);
    fast     = div_zero || div_ovf;
    // funct3[1] separates remainder ops (REM/REMU) from quotient ops
    if (div_zero)
      fast_res = bus.funct3_i[1] ? bus.rs1_i : 32'hFFFF_FFFF;
    else
      fast_res = bus.funct3_i[1] ? 32'd0 : 32'h8000_0000;
    accept   = (state == IDLE) && bus.valid_i && !bus.flush_i;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and handshake outputs; a flush overrides everything
  always_comb begin
    state_nx    = state;
    bus.stall_o = 1'b0;
    bus.done_o  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx    = fast ? DONE : CALC;
          bus.stall_o = 1'b1;
        end
      end
      CALC: begin
        bus.stall_o = 1'b1;
        if (cnt == 5'd31) state_nx = FIX;
      end
      FIX: begin
        bus.stall_o = 1'b1;
        state_nx    = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (bus.flush_i) begin
      state_nx    = IDLE;
      bus.stall_o = 1'b0;
      bus.done_o  = 1'b0;
    end
    // Async reset is immediate on the outputs too, not just at the next edge
    if (rst_i) begin
      bus.stall_o = 1'b0;
      bus.done_o  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One iteration step for each algorithm
  // ---------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] div_sh, div_trial;
  logic        q_bit;
  logic [63:0] div_nx;

  // Shift-add multiply step and restoring divide step
  always_comb begin
    // Add multiplicand when the multiplier LSB is set, then shift the whole pair right
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_nx    = {mul_sum, acc[31:1]};
    // Bring down the next dividend bit; the remainder is below the divisor so 33 bits hold the trial
    div_sh    = {acc[63:32], acc[31]};
    div_trial = div_sh - {1'b0, opnd};
    q_bit     = !div_trial[32];
    div_nx    = {(q_bit ? div_trial[31:0] : div_sh[31:0]), acc[30:0], q_bit};
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up and result selection
  // ---------------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, fix_res;

  // Apply signs to the magnitude result and pick the requested half
  always_comb begin
    prod_fix = neg_p ? (64'd0 - acc) : acc;
    quot_fix = neg_p ? (32'd0 - acc[31:0]) : acc[31:0];
    rem_fix  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
    case (op)
      3'b000:                 fix_res = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[63:32];
      3'b100, 3'b101:         fix_res = quot_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Operand latch at issue and one iteration per CALC cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt   <= 5'd0;
      acc   <= 64'd0;
      opnd  <= 32'd0;
      op    <= 3'd0;
      rd_q  <= 5'd0;
      neg_p <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      cnt   <= 5'd0;
      acc   <= {32'd0, (is_div ? mag_a : mag_b)};
      opnd  <= is_div ? mag_b : mag_a;
      op    <= bus.funct3_i;
      rd_q  <= bus.rd_i;
      neg_p <= sign_a ^ sign_b;
      neg_r <= sign_a;
    end else if (state == CALC) begin
      cnt <= cnt + 5'd1;
      acc <= op[2] ? div_nx : mul_nx;
    end
  end

  // Architectural result: updated only by FIX or a fast-path issue, otherwise held
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      result_q <= 32'd0;
      rd_oq    <= 5'd0;
    end else if (accept && fast) begin
      result_q <= fast_res;
      rd_oq    <= bus.rd_i;
    end else if (state == FIX && !bus.flush_i) begin
      result_q <= fix_res;
      rd_oq    <= rd_q;
    end
  end

  assign bus.result_o = result_q;
  assign bus.rd_o     = rd_oq;
endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: directed vector table, random ops against an arithmetic model,
// plus flush and reset-abort sequences.
module tb_exe_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] last_res;

  exe_muldiv_if bus ();
  exe_muldiv dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    longint unsigned up;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op at posedge+1 (IDLE) and follow it to done_o, checking stall each cycle
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int  c = 0;
    bit  seen = 0;
    bit  stall_ok = 1;
    logic [31:0] res;
    logic [4:0]  rdo;
    bus.valid_i  = 1'b1;
    bus.funct3_i = f3;
    bus.rs1_i    = a;
    bus.rs2_i    = b;
    bus.rd_i     = rd;
    while (!seen && c < 60) begin
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1;
        res  = bus.result_o;
        rdo  = bus.rd_o;
        if (bus.stall_o) stall_ok = 0;
      end else begin
        if (!bus.stall_o) stall_ok = 0;
        c++;
      end
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(c), 32'(lat));
    chk({name, " stall"}, 32'(stall_ok), 32'd1);
    if (seen) begin
      chk({name, " result"}, res, exp);
      chk({name, " rd"}, 32'(rdo), 32'(rd));
    end
    last_res = exp;
  endtask

  vec_t vt[$];

  initial begin
    bus.valid_i = 1'b1; bus.funct3_i = 3'd0; bus.rs1_i = 32'd1; bus.rs2_i = 32'd1;
    bus.rd_i = 5'd1; bus.flush_i = 1'b0;

    // Reset: outputs idle even with a valid request pending
    repeat (2) @(negedge clk);
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst result", bus.result_o, 32'd0);
    chk("rst rd", 32'(bus.rd_o), 32'd0);
    bus.valid_i = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    vt.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34});
    vt.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34});
    vt.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34});
    vt.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 34});
    vt.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34});
    vt.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34});
    vt.push_back('{3'd5, 32'd100,        32'd7,         5'd11, 32'd14,        34});
    vt.push_back('{3'd7, 32'd100,        32'd7,         5'd12, 32'd2,         34});
    vt.push_back('{3'd5, 32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1});
    vt.push_back('{3'd6, 32'd5,          32'd0,         5'd14, 32'd5,         1});
    vt.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1});
    vt.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1});
    vt.push_back('{3'd7, 32'hDEAD_BEEF,  32'd1,         5'd17, 32'd0,         34});
    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].lat);

    // Random ops back-to-back, with edge operands mixed in
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), f3, a, b, 5'($urandom), model(f3, a, b), model_lat(f3, a, b));
    end

    // Flush in cycle 10 of a DIV
    bus.valid_i = 1'b1; bus.funct3_i = 3'd4; bus.rs1_i = 32'd1000; bus.rs2_i = 32'd3; bus.rd_i = 5'd3;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(negedge clk);
    chk("flush stall", 32'(bus.stall_o), 32'd0);
    chk("flush done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    begin
      bit any_done = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (bus.done_o || bus.stall_o) any_done = 1;
      end
      chk("flush quiet", 32'(any_done), 32'd0);
    end
    chk("flush result held", bus.result_o, last_res);
    @(posedge clk); #1;
    run_op("post-flush mul", 3'd0, 32'd3, 32'd4, 5'd21, 32'd12, 34);

    // Reset in cycle 20 of a MUL
    bus.valid_i = 1'b1; bus.funct3_i = 3'd0; bus.rs1_i = 32'd9; bus.rs2_i = 32'd9; bus.rd_i = 5'd4;
    for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst stall", 32'(bus.stall_o), 32'd0);
    chk("midrst done", 32'(bus.done_o), 32'd0);
    chk("midrst result", bus.result_o, 32'd0);
    chk("midrst rd", 32'(bus.rd_o), 32'd0);
    bus.valid_i = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    begin
      bit any_done = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.done_o) any_done = 1;
      end
      chk("midrst no done", 32'(any_done), 32'd0);
    end
    @(posedge clk); #1;
    run_op("b2b mul", 3'd0, 32'd123, 32'd456, 5'd22, 32'd56088, 34);
    run_op("b2b divu", 3'd5, 32'd1000, 32'd7, 5'd23, 32'd142, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1);
  end
endmodule
